// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Queues ALU commands in a small FIFO and issues them one at a time to an
// external combinational ALU. Each result is captured with its opcode and
// zero/negative flags, then held until the downstream consumer accepts it.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (cmd_ready = FIFO not full)
//   cmd_op, cmd_a, cmd_b  : opcode and operands of the offered command
//   alu_a, alu_b, alu_op  : registered operands/opcode driving the ALU
//   alu_result            : combinational ALU output
//   res_valid/res_ready   : result handshake
//   res_data, res_op      : captured result and the opcode that produced it
//   res_zero, res_neg     : res_data == 0, res_data sign bit
//   busy                  : FIFO non-empty or a command in flight
//   done_cnt              : completed result handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [2:0]       res_op,
   output logic             res_zero,
   output logic             res_neg,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = 3 + 2 * WIDTH;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] DONE_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [2:0]       res_op_q, res_op_d;
   logic             res_zero_q, res_zero_d;
   logic             res_neg_q, res_neg_d;
   logic             busy_q, busy_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
   logic             push_s;
   logic             pop_s;
   logic             fifo_nempty_s;

   // Next-state, FIFO bookkeeping and output register computation
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      res_zero_d  = res_zero_q;
      res_neg_d   = res_neg_q;
      done_cnt_d  = done_cnt_q;
      pop_s       = 1'b0;
      // cmd_ready_q already reflects "not full", so push never overflows
      push_s        = cmd_valid && cmd_ready_q;
      fifo_nempty_s = (count_q != {(PTR_W + 1){1'b0}});

      case (state_q)
         ST_IDLE: begin
            if (fifo_nempty_s) begin
               pop_s   = 1'b1;
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            res_data_d  = alu_result;
            res_op_d    = alu_op_q;
            res_zero_d  = (alu_result == {WIDTH{1'b0}});
            res_neg_d   = alu_result[WIDTH-1];
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               done_cnt_d  = done_cnt_q + DONE_ONE;
               res_valid_d = 1'b0;
               if (fifo_nempty_s) begin
                  pop_s   = 1'b1;
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      // Head entry goes straight into the ALU operand registers
      if (pop_s) begin
         {alu_op_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_s) begin
         mem_d[wr_ptr_q] = {cmd_op, cmd_a, cmd_b};
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // Status flags are registered from the next-state values so they
      // line up with the FIFO/state they describe
      busy_d      = (count_d != {(PTR_W + 1){1'b0}}) || (state_d != ST_IDLE);
      cmd_ready_d = (count_d != FULL_CNT);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {ENT_W{1'b0}};
         end
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {(PTR_W + 1){1'b0}};
         alu_a_q     <= {WIDTH{1'b0}};
         alu_b_q     <= {WIDTH{1'b0}};
         alu_op_q    <= 3'd0;
         res_valid_q <= 1'b0;
         res_data_q  <= {WIDTH{1'b0}};
         res_op_q    <= 3'd0;
         res_zero_q  <= 1'b0;
         res_neg_q   <= 1'b0;
         busy_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
         done_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
         res_zero_q  <= res_zero_d;
         res_neg_q   <= res_neg_d;
         busy_q      <= busy_d;
         cmd_ready_q <= cmd_ready_d;
         done_cnt_q  <= done_cnt_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign res_zero  = res_zero_q;
   assign res_neg   = res_neg_q;
   assign busy      = busy_q;
   assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Self-checking bench: an external ALU model drives alu_result, and a queue of
// expected {opcode, result} pairs (computed at command acceptance) is matched
// against every result handshake.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [2:0]       res_op;
   logic             res_zero;
   logic             res_neg;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   int errors   = 0;
   int checks   = 0;
   int done_exp = 0;
   int accepted = 0;
   logic [WIDTH+2:0] exp_q[$];

   alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_op(res_op),
      .res_zero(res_zero), .res_neg(res_neg),
      .busy(busy), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   // External combinational ALU: bit 0 of the unary ops selects operand B
   logic [WIDTH-1:0] alu_sel;
   always_comb begin
      alu_sel = alu_op[0] ? alu_b : alu_a;
      case (alu_op)
         3'd0:       alu_result = alu_a + alu_b;
         3'd1:       alu_result = alu_a - alu_b;
         3'd2, 3'd3: alu_result = alu_sel;
         3'd4, 3'd5: alu_result = alu_sel - WIDTH'(1);
         default:    alu_result = alu_sel + WIDTH'(1);
      endcase
   end

   function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a;
         3'd3:    return b;
         3'd4:    return a - WIDTH'(1);
         3'd5:    return b - WIDTH'(1);
         3'd6:    return a + WIDTH'(1);
         default: return b + WIDTH'(1);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return {WIDTH{1'b0}};
         1:       return {WIDTH{1'b1}};
         default: return WIDTH'($urandom);
      endcase
   endfunction

   task automatic drive_random_cmd();
      cmd_op = 3'($urandom_range(0, 7));
      cmd_a  = rand_operand();
      cmd_b  = rand_operand();
   endtask

   // One clock cycle: score handshakes seen before the edge, then check
   // hold stability, done_cnt and busy after the edge.
   task automatic step();
      logic [WIDTH+2:0] e;
      logic             cmd_hs;
      logic             res_hs;
      logic             was_hold;
      logic [WIDTH-1:0] hold_data;
      logic [2:0]       hold_op;
      cmd_hs    = cmd_valid && cmd_ready;
      res_hs    = res_valid && res_ready;
      was_hold  = res_valid && !res_ready;
      hold_data = res_data;
      hold_op   = res_op;
      if (res_hs) begin
         if (exp_q.size() == 0) begin
            chk("spurious_result", 64'(res_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("res_data", 64'(res_data), 64'(e[WIDTH-1:0]));
            chk("res_op", 64'(res_op), 64'(e[WIDTH+2:WIDTH]));
            chk("res_zero", 64'(res_zero), 64'(e[WIDTH-1:0] == {WIDTH{1'b0}}));
            chk("res_neg", 64'(res_neg), 64'(e[WIDTH-1]));
            done_exp = (done_exp + 1) % (1 << CNT_W);
         end
      end
      if (cmd_hs) begin
         exp_q.push_back({cmd_op, ref_result(cmd_op, cmd_a, cmd_b)});
         accepted++;
      end
      @(posedge clk);
      #1;
      if (was_hold) begin
         chk("hold_valid", 64'(res_valid), 64'd1);
         chk("hold_data", 64'(res_data), 64'(hold_data));
         chk("hold_op", 64'(res_op), 64'(hold_op));
      end
      chk("done_cnt", 64'(done_cnt), 64'(done_exp));
      chk("busy", 64'(busy), 64'(exp_q.size() != 0));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      chk({tag, "_res_data"}, 64'(res_data), 64'd0);
      chk({tag, "_res_op"}, 64'(res_op), 64'd0);
      chk({tag, "_res_zero"}, 64'(res_zero), 64'd0);
      chk({tag, "_res_neg"}, 64'(res_neg), 64'd0);
      chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
      chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
      chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
   endtask

   // Called just after an edge: reset asserted mid-cycle, checked before
   // the next edge, released mid-cycle.
   task automatic do_reset(input string tag);
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_values(tag);
      exp_q.delete();
      done_exp = 0;
      accepted = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 100 && busy; i++) begin
         step();
      end
      chk({tag, "_drain_done"}, 64'(busy), 64'd0);
   endtask

   // Single command into an idle sequencer with directed expectations
   task automatic single(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_data,
                         input logic exp_zero, input logic exp_neg);
      res_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_a = a; cmd_b = b;
      step();
      cmd_valid = 1'b0;
      chk({tag, "_valid_k"}, 64'(res_valid), 64'd0);
      step();
      chk({tag, "_valid_k1"}, 64'(res_valid), 64'd0);
      step();
      chk({tag, "_valid_k2"}, 64'(res_valid), 64'd1);
      chk({tag, "_data"}, 64'(res_data), 64'(exp_data));
      chk({tag, "_op"}, 64'(res_op), 64'(op));
      chk({tag, "_zero"}, 64'(res_zero), 64'(exp_zero));
      chk({tag, "_neg"}, 64'(res_neg), 64'(exp_neg));
      step();
      chk({tag, "_valid_after"}, 64'(res_valid), 64'd0);
   endtask

   initial begin
      logic [WIDTH+2:0] cmds [6];
      logic             hist [60];
      int               highs;
      int               pairs;

      rst_n = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_op = 3'd0; cmd_a = '0; cmd_b = '0;
      #2 rst_n = 1'b0;
      #1 check_reset_values("por");
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic operations and latency
      single("add", 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
      chk("add_done_cnt", 64'(done_cnt), 64'd1);
      single("sub", 3'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      single("adec", 3'd4, 32'd1, 32'd9, 32'd0, 1'b1, 1'b0);
      single("passb", 3'd3, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      single("binc", 3'd7, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
      single("bdec", 3'd5, 32'd3, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
      single("passa", 3'd2, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
      single("ainc", 3'd6, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);

      // Backpressure: 6 commands offered, 5 accepted
      do_reset("rst_bp");
      for (int i = 0; i < 6; i++) begin
         cmds[i] = {3'($urandom_range(0, 7)), rand_operand(), rand_operand()};
      end
      for (int c = 0; c < 14; c++) begin
         if (accepted < 6) begin
            cmd_valid = 1'b1;
            {cmd_op, cmd_a, cmd_b} = cmds[accepted];
         end else begin
            cmd_valid = 1'b0;
         end
         step();
      end
      chk("bp_accepted", 64'(accepted), 64'd5);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_res_valid", 64'(res_valid), 64'd1);
      drain("bp");
      chk("bp_done_cnt", 64'(done_cnt), 64'd5);

      // Peak throughput with continuous commands
      res_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         cmd_valid = 1'b1;
         drive_random_cmd();
         step();
         hist[c] = res_valid;
      end
      highs = 0;
      pairs = 0;
      for (int c = 20; c < 60; c++) begin
         if (hist[c]) highs++;
         if (hist[c] && hist[c-1]) pairs++;
      end
      chk("tput_highs", 64'(highs), 64'd20);
      chk("tput_back_to_back", 64'(pairs), 64'd0);
      drain("tput");

      // Random traffic with random backpressure
      for (int c = 0; c < 400; c++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         res_ready = ($urandom_range(0, 3) != 0);
         drive_random_cmd();
         step();
      end
      drain("rand");

      // done_cnt wrap: 17 results on a 4-bit counter
      do_reset("rst_wrap");
      for (int n = 0; n < 17; n++) begin
         cmd_valid = 1'b1;
         drive_random_cmd();
         res_ready = 1'b1;
         step();
         drain("wrap");
      end
      chk("wrap_done_cnt", 64'(done_cnt), 64'd1);

      // Reset in HOLD with 3 queued discards everything
      do_reset("rst_pre_hold");
      for (int c = 0; c < 8; c++) begin
         cmd_valid = (accepted < 4);
         drive_random_cmd();
         step();
      end
      chk("hold_accepted", 64'(accepted), 64'd4);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      do_reset("rst_hold");
      res_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk("post_reset_valid", 64'(res_valid), 64'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
